// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI frame master sending {cmd,data} MSB first, with read-data reception.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_cmd/req_data request handshake;
// SS_n/MOSI/MISO SPI pins; rsp_valid/rsp_data read-byte response; busy high outside IDLE.
// Optional macro SPI_MASTER_DRIVER_FRAME_CNT_EN adds 16-bit frame_cnt output.
module spi_master_driver #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic       busy
);
  localparam int GE = (GAP < 1) ? 1 : GAP;
  typedef enum logic [2:0] {IDLE, CHK, SHIFT, WAIT, RECV, GAP_ST} state_t;
  state_t      r_state;
  logic        r_ready, r_busy, r_ss_n, r_mosi, r_rsp_valid;
  logic [9:0]  r_sh;
  logic [3:0]  r_bit;
  logic [15:0] r_cnt;
  logic [7:0]  r_rx, r_rsp_data;
  logic [15:0] r_frame_cnt;
  logic        w_fin;
  assign w_fin = (r_state == SHIFT && r_bit == 4'd0 && r_sh[9:8] != 2'b11) ||
                 (r_state == RECV && r_bit == 4'd0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_sh        <= 10'h000;
      r_bit       <= 4'd0;
      r_cnt       <= 16'd0;
      r_rx        <= 8'h00;
      r_frame_cnt <= 16'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_fin) r_frame_cnt <= r_frame_cnt + 16'd1;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          // r_ready gates acceptance so nothing is taken on the first edge after reset
          if (req_valid && r_ready) begin
            r_state <= CHK;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_ss_n  <= 1'b0;
            r_mosi  <= req_cmd[1];
            r_sh    <= {req_cmd, req_data};
            r_bit   <= 4'd9;
          end
        end
        CHK: begin
          r_state <= SHIFT;
          r_mosi  <= r_sh[9];
        end
        SHIFT: begin
          if (r_bit != 4'd0) begin
            r_bit  <= r_bit - 4'd1;
            r_mosi <= r_sh[r_bit - 4'd1];
          end else if (r_sh[9:8] == 2'b11) begin
            r_mosi  <= 1'b0;
            r_bit   <= 4'd7;
            r_state <= (RD_WAIT > 0) ? WAIT : RECV;
            r_cnt   <= (RD_WAIT > 0) ? 16'(RD_WAIT - 1) : 16'd0;
          end else begin
            r_state <= GAP_ST;
            r_ss_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_cnt   <= 16'(GE - 1);
          end
        end
        WAIT: begin
          if (r_cnt == 16'd0) r_state <= RECV;
          else r_cnt <= r_cnt - 16'd1;
        end
        RECV: begin
          r_rx <= {r_rx[6:0], MISO};
          if (r_bit == 4'd0) begin
            r_state     <= GAP_ST;
            r_ss_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= {r_rx[6:0], MISO};
            r_cnt       <= 16'(GE - 1);
          end else begin
            r_bit <= r_bit - 4'd1;
          end
        end
        GAP_ST: begin
          if (r_cnt == 16'd0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
  assign frame_cnt = r_frame_cnt;
`else
  logic w_unused;
  assign w_unused = ^r_frame_cnt;
`endif
endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: directed and random frames checked against a frame-level reference model.
module tb_spi_master_driver;
  localparam int RD = 2;
  localparam int G  = 1;
  localparam int GE = (G < 1) ? 1 : G;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       MISO = 1'b0;
  logic       req_ready, SS_n, MOSI, rsp_valid, busy;
  logic [7:0] rsp_data;
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  int total = 0;
  int bad = 0;
  logic [7:0]  last_rd = 8'h00;
  logic [15:0] fc_model = 16'd0;
  spi_master_driver #(.RD_WAIT(RD), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m, input bit hold);
    int t = 0;
    int len = (c == 2'b11) ? 19 + RD : 11;
    logic [9:0] fr = {c, d};
    logic [7:0] mb = m;
    logic exp_bit;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 32'(t < 100), 32'd1);
    req_valid = 1'b1;
    req_cmd = c;
    req_data = d;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp_bit = (k == 0) ? c[1] : (k <= 10) ? fr[10 - k] : 1'b0;
      chk("ss_low", 32'(SS_n), 32'd0);
      chk("mosi", 32'(MOSI), 32'(exp_bit));
      chk("ready_in_frame", 32'(req_ready), 32'd0);
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("rsp_valid_in_frame", 32'(rsp_valid), 32'd0);
      MISO = (k >= 11 + RD && k < 19 + RD) ? mb[18 + RD - k] : 1'($urandom);
      @(negedge clk);
    end
    if (c == 2'b11) last_rd = m;
    fc_model = fc_model + 16'd1;
    for (int g = 0; g < GE; g++) begin
      chk("ss_gap", 32'(SS_n), 32'd1);
      chk("mosi_gap", 32'(MOSI), 32'd0);
      chk("busy_gap", 32'(busy), 32'd1);
      chk("ready_gap", 32'(req_ready), 32'd0);
      chk("rsp_valid_pulse", 32'(rsp_valid), (g == 0 && c == 2'b11) ? 32'd1 : 32'd0);
      chk("rsp_data_hold", 32'(rsp_data), 32'(last_rd));
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(fc_model));
`endif
      @(negedge clk);
    end
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ss", 32'(SS_n), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    run_frame(2'b00, 8'h5A, 8'h00, 1'b0);
    run_frame(2'b11, 8'h00, 8'hC3, 1'b0);
    run_frame(2'b01, 8'hA5, 8'h00, 1'b0);
    run_frame(2'b10, 8'h3C, 8'h00, 1'b0);
    run_frame(2'b00, 8'h12, 8'h00, 1'b1);
    run_frame(2'b11, 8'h34, 8'h7E, 1'b1);
    run_frame(2'b01, 8'h56, 8'h00, 1'b1);
    run_frame(2'b11, 8'h78, 8'h81, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("no_extra_accept", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++)
      run_frame(2'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    req_valid = 1'b1;
    req_cmd = 2'b11;
    req_data = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 15 + RD; k++) begin
      MISO = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ss", 32'(SS_n), 32'd1);
    chk("midrst_mosi", 32'(MOSI), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    last_rd = 8'h00;
    fc_model = 16'd0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_no_pulse", 32'(rsp_valid), 32'd0);
    run_frame(2'b11, 8'h9F, 8'h5D, 1'b0);
    run_frame(2'b00, 8'hFF, 8'h00, 1'b0);
`ifdef SPI_MASTER_DRIVER_FRAME_CNT_EN
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    fc_model = 16'hFFFF;
    @(negedge clk);
    run_frame(2'b00, 8'h01, 8'h00, 1'b0);
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
